// File: rtl/unum_pkg.sv
// Shared constants for the quire-to-posit back end: posit format, quire
// geometry and the drain FSM state encoding.
package unum_pkg;

    localparam int WORD_W = 64;
    localparam int QWORDS = 8;
    localparam int NBITS  = 32;
    localparam int ES     = 2;

    // Scale window representable by a 32-bit es=2 posit: useed^30 = 2^120.
    localparam logic signed [9:0] MAX_SCALE = 10'sd120;

    localparam logic [NBITS-1:0] POSIT_MAXPOS = 32'h7FFF_FFFF;
    localparam logic [NBITS-1:0] POSIT_MINPOS = 32'h0000_0001;
    localparam logic [NBITS-1:0] POSIT_NAR    = 32'h8000_0000;
    localparam logic [NBITS-1:0] POSIT_ZERO   = 32'h0000_0000;

    typedef logic [2:0] state_t;

    localparam state_t S_LOAD   = 3'd0;
    localparam state_t S_ABS    = 3'd1;
    localparam state_t S_SEARCH = 3'd2;
    localparam state_t S_NORM   = 3'd3;
    localparam state_t S_ENCODE = 3'd4;
    localparam state_t S_OUT    = 3'd5;

endpackage

// File: rtl/lzc64.sv
// 64-bit leading-zero counter. The count is 7 bits wide so that an all-zero
// word can report 64.
module lzc64 (
    input  logic [63:0] din,
    output logic [6:0]  cnt
);

    // Scan upward so the highest set bit has the final say.
    always_comb begin
        cnt = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (din[i]) cnt = 7'(63 - i);
        end
    end

endmodule

// File: rtl/quire_to_unum.sv
// Drains a 512-bit two's-complement quire word-serially, takes its magnitude,
// normalises around the leading one and rounds to a 32-bit es=2 posit
// (round-to-nearest-even, saturating, NaR override).
module quire_to_unum
    import unum_pkg::*;
#(
    parameter int QWORDS_P = QWORDS,
    parameter int QBIAS    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_unum,
    output logic        busy
);

    localparam int CW = $clog2(QWORDS_P);

    state_t                        state;
    logic [QWORDS_P-1:0][63:0]     q;
    logic [CW-1:0]                 cnt;
    logic                          inf_l;
    logic                          sign;
    logic                          carry;
    logic [QWORDS_P-1:0]           nz;
    logic [CW-1:0]                 w;
    logic                          zero;
    logic [9:0]                    s;
    logic [31:0]                   frac;
    logic                          stk;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state != S_LOAD);

    // ABS: one word of the serial negate per cycle; carry-in is 1 on word 0.
    logic [64:0] neg_sum;
    logic        cin;
    always_comb begin
        cin     = (cnt == '0) ? 1'b1 : carry;
        neg_sum = sign ? ({1'b0, ~q[cnt]} + 65'(cin)) : {1'b0, q[cnt]};
    end

    // SEARCH: index of the most significant nonzero magnitude word.
    logic [CW-1:0] w_n;
    always_comb begin
        w_n = '0;
        for (int i = 0; i < QWORDS_P; i++) begin
            if (nz[i]) w_n = CW'(i);
        end
    end

    // NORM: left-justify the two-word window on the leading one of word w.
    logic [63:0]  hi, lo;
    logic [6:0]   p;
    logic [126:0] win;
    logic         stk_nz;
    logic [9:0]   s_n;

    lzc64 u_lzc (.din(hi), .cnt(p));

    always_comb begin
        hi     = q[w];
        lo     = (w == '0) ? 64'd0 : q[w - CW'(1)];
        win    = 127'({hi, lo} << p);
        stk_nz = 1'b0;
        for (int j = 0; j < QWORDS_P; j++) begin
            if (j + 1 < int'(w)) stk_nz = stk_nz | nz[j];
        end
        s_n = 10'({w, 6'd0}) + 10'd63 - 10'(p) - 10'(QBIAS);
    end

    // ENCODE: an arithmetic right shift of {~neg, neg, e, frac} lays down the
    // regime run (k+1 ones then 0, or -k zeros then 1) ahead of e and frac.
    logic signed [9:0] ss;
    logic              neg;
    logic [4:0]        amt;
    logic [95:0]       v, r;
    logic [30:0]       body, body_f;
    logic              guard, st_all;
    logic [31:0]       rnd;
    logic [31:0]       res;
    always_comb begin
        ss     = s;
        neg    = s[9];
        amt    = neg ? ~s[6:2] : s[6:2];
        v      = {~neg, neg, s[1:0], frac, 60'd0};
        r      = $signed(v) >>> amt;
        body   = r[95:65];
        guard  = r[64];
        st_all = stk | (|r[63:0]);
        rnd    = {1'b0, body} + 32'(guard & (body[0] | st_all));
        if (ss > MAX_SCALE || rnd[31])
            body_f = POSIT_MAXPOS[30:0];
        else if (ss < -MAX_SCALE)
            body_f = POSIT_MINPOS[30:0];
        else
            body_f = rnd[30:0];
        res = sign ? (32'd0 - {1'b0, body_f}) : {1'b0, body_f};
        if (zero)  res = POSIT_ZERO;
        if (inf_l) res = POSIT_NAR;
    end

    // Drain FSM and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_LOAD;
            q         <= '0;
            cnt       <= '0;
            inf_l     <= 1'b0;
            sign      <= 1'b0;
            carry     <= 1'b0;
            nz        <= '0;
            w         <= '0;
            zero      <= 1'b0;
            s         <= '0;
            frac      <= '0;
            stk       <= 1'b0;
            out_valid <= 1'b0;
            out_unum  <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        q[cnt] <= in_data;
                        inf_l  <= inf_l | in_inf;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(QWORDS_P - 1)) begin
                            sign  <= in_data[63];
                            state <= S_ABS;
                        end
                    end
                end
                S_ABS: begin
                    q[cnt]  <= neg_sum[63:0];
                    carry   <= neg_sum[64];
                    nz[cnt] <= |neg_sum[63:0];
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(QWORDS_P - 1)) state <= S_SEARCH;
                end
                S_SEARCH: begin
                    w     <= w_n;
                    zero  <= ~|nz;
                    state <= S_NORM;
                end
                S_NORM: begin
                    s     <= s_n;
                    frac  <= win[126:95];
                    stk   <= (|win[94:0]) | stk_nz;
                    state <= S_ENCODE;
                end
                S_ENCODE: begin
                    out_unum  <= res;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        inf_l     <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
